// File: rtl/qoi_types.sv
// Shared widths and the sequencer state encoding for the QOI buffer path.
package qoi_types;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [7:0]        byte_t;
    typedef logic [ADDR_W:0]   len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_PIX_HOLD,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam len_t  LEN_FULL  = len_t'(DEPTH);
    localparam addr_t ADDR_LAST = '1;

endpackage

// File: rtl/enc_hold_reg.sv
// One-entry valid/ready holding register for the encoded byte stream;
// ready is withheld while the entry is occupied, so there is no bypass path.
module enc_hold_reg
    import qoi_types::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  pop_i,
    input  byte_t data_i,
    input  logic  valid_i,
    input  logic  last_i,
    output logic  ready_o,
    output logic  valid_o,
    output byte_t data_o,
    output logic  last_o
);

    logic  valid_q;
    byte_t data_q;
    logic  last_q;

    assign ready_o = en_i & ~valid_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

    // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/qoi_buffer_sequencer.sv
// Port-B owner: streams the input buffer to the QOI encoder and stores the
// encoded bytes into the output buffer, then hands the buffers back.
module qoi_buffer_sequencer
    import qoi_types::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    output logic  sel_o,
    output addr_t addr_b_o,
    output byte_t data_b_o,
    input  byte_t data_b_i,
    output logic  cs_b_o,
    output logic  we_b_o,
    output byte_t pix_data_o,
    output logic  pix_valid_o,
    input  logic  pix_ready_i,
    output logic  pix_last_o,
    input  byte_t enc_data_i,
    input  logic  enc_valid_i,
    output logic  enc_ready_o,
    input  logic  enc_last_i,
    output logic  busy_o,
    output logic  done_o,
    output len_t  out_len_o,
    output logic  overflow_o
);

    seq_state_t state_q;
    logic       sel_q;
    addr_t      rd_ptr_q;
    addr_t      wr_ptr_q;
    len_t       out_len_q;
    logic       overflow_q;
    logic       pix_done_q;
    logic       enc_done_q;
    byte_t      pix_data_q;
    logic       pix_valid_q;
    logic       pix_last_q;

    logic       hold_valid;
    byte_t      hold_data;
    logic       hold_last;
    logic       buf_full;
    logic       do_write;
    logic       do_read;

    enc_hold_reg u_hold (
        .clk     (clk),
        .rst     (rst),
        .en_i    (sel_q),
        .pop_i   (sel_q & hold_valid),
        .data_i  (enc_data_i),
        .valid_i (enc_valid_i),
        .last_i  (enc_last_i),
        .ready_o (enc_ready_o),
        .valid_o (hold_valid),
        .data_o  (hold_data),
        .last_o  (hold_last)
    );

    // A held byte always consumes the port slot, even when it is discarded on overflow.
    assign buf_full = (out_len_q == LEN_FULL);
    assign do_write = sel_q & hold_valid & ~buf_full;
    assign do_read  = sel_q & ~hold_valid & (state_q == ST_RD_ISSUE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cs_b_o   = 1'b0;
        we_b_o   = 1'b0;
        addr_b_o = '0;
        data_b_o = '0;
        if (do_write) begin
            cs_b_o   = 1'b1;
            we_b_o   = 1'b1;
            addr_b_o = wr_ptr_q;
            data_b_o = hold_data;
        end else if (do_read) begin
            cs_b_o   = 1'b1;
            addr_b_o = rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            out_len_q   <= '0;
            overflow_q  <= 1'b0;
            pix_done_q  <= 1'b0;
            enc_done_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            if (sel_q && hold_valid) begin
                if (buf_full) begin
                    overflow_q <= 1'b1;
                end else begin
                    wr_ptr_q  <= (wr_ptr_q == ADDR_LAST) ? wr_ptr_q : wr_ptr_q + 1'b1;
                    out_len_q <= out_len_q + 1'b1;
                end
                if (hold_last) enc_done_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rd_ptr_q   <= '0;
                        wr_ptr_q   <= '0;
                        out_len_q  <= '0;
                        overflow_q <= 1'b0;
                        pix_done_q <= 1'b0;
                        enc_done_q <= 1'b0;
                        sel_q      <= 1'b1;
                        state_q    <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (!hold_valid) state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    pix_data_q  <= data_b_i;
                    pix_valid_q <= 1'b1;
                    pix_last_q  <= (rd_ptr_q == ADDR_LAST);
                    state_q     <= ST_PIX_HOLD;
                end
                ST_PIX_HOLD: begin
                    if (pix_ready_i) begin
                        pix_valid_q <= 1'b0;
                        pix_last_q  <= 1'b0;
                        if (pix_last_q) begin
                            pix_done_q <= 1'b1;
                            state_q    <= ST_DRAIN;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            state_q  <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pix_done_q && enc_done_q && !hold_valid) begin
                        sel_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel_o       = sel_q;
    assign pix_data_o  = pix_data_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_last_o  = pix_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign out_len_o   = out_len_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_qoi_buffer_sequencer.sv
// Self-checking bench: memory-unit model plus encoder/pixel-sink drivers,
// checked against buffer contents and stream order derived from the frame rules.
module tb_qoi_buffer_sequencer;
    import qoi_types::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  start_i = 1'b0;
    logic  sel_o;
    addr_t addr_b_o;
    byte_t data_b_o;
    byte_t data_b_i = '0;
    logic  cs_b_o;
    logic  we_b_o;
    byte_t pix_data_o;
    logic  pix_valid_o;
    logic  pix_ready_i = 1'b0;
    logic  pix_last_o;
    byte_t enc_data_i = '0;
    logic  enc_valid_i = 1'b0;
    logic  enc_ready_o;
    logic  enc_last_i = 1'b0;
    logic  busy_o;
    logic  done_o;
    len_t  out_len_o;
    logic  overflow_o;

    always #5 clk = ~clk;

    qoi_buffer_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .sel_o       (sel_o),
        .addr_b_o    (addr_b_o),
        .data_b_o    (data_b_o),
        .data_b_i    (data_b_i),
        .cs_b_o      (cs_b_o),
        .we_b_o      (we_b_o),
        .pix_data_o  (pix_data_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .pix_last_o  (pix_last_o),
        .enc_data_i  (enc_data_i),
        .enc_valid_i (enc_valid_i),
        .enc_ready_o (enc_ready_o),
        .enc_last_i  (enc_last_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .out_len_o   (out_len_o),
        .overflow_o  (overflow_o)
    );

    // Memory unit model: port B reads the input buffer, writes the output buffer.
    byte_t in_buf [DEPTH];
    byte_t out_buf[DEPTH];
    logic  clr_out = 1'b0;

    always @(posedge clk) begin
        if (clr_out) begin
            for (int i = 0; i < DEPTH; i++) out_buf[i] <= 8'hEE;
        end else if (cs_b_o) begin
            if (we_b_o) out_buf[addr_b_o] <= data_b_o;
            else        data_b_i <= in_buf[addr_b_o];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int n_enc;
        int ready_pct;
        int valid_pct;
        int bp_at;
        bit start_mid;
        int exp_len;
        bit exp_ovf;
    } frame_vec_t;

    frame_vec_t vecs[6];

    int    acc_cyc [$];
    logic  acc_we  [$];
    addr_t acc_addr[$];

    task automatic run_frame(input int id, input int n_enc, input int ready_pct,
                             input int valid_pct, input int bp_at, input bit start_mid,
                             input bit rand_data, input int exp_len, input bit exp_ovf);
        byte_t enc_bytes[$];
        byte_t pix_q[$];
        logic  pixl_q[$];
        int    enc_idx = 0;
        int    dones = 0;
        int    post = 0;
        int    writes = 0;
        int    bp_cnt = 0;
        bit    enc_hs = 0;
        bit    prev_hs;
        bit    holding;
        int    model_len;
        string tag;

        tag = $sformatf("f%0d", id);
        for (int i = 0; i < DEPTH; i++) in_buf[i] = rand_data ? byte_t'($urandom) : byte_t'(i);
        for (int i = 0; i < n_enc; i++) enc_bytes.push_back(rand_data ? byte_t'($urandom) : byte_t'(8'hA0 + i));
        acc_cyc.delete(); acc_we.delete(); acc_addr.delete();

        @(negedge clk); clr_out = 1'b1;
        @(negedge clk); clr_out = 1'b0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;

        for (int cyc = 1; cyc <= 3000 && post < 3; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (dones > 0) post++;
            if (done_o) dones++;
            start_i = (start_mid && cyc == 20);

            prev_hs = enc_hs;
            if (prev_hs) enc_idx++;
            holding = enc_valid_i && !prev_hs;
            if (!holding) begin
                if (enc_idx < n_enc && ($urandom % 100) < valid_pct) begin
                    enc_valid_i = 1'b1;
                    enc_data_i  = enc_bytes[enc_idx];
                    enc_last_i  = (enc_idx == n_enc - 1);
                end else begin
                    enc_valid_i = 1'b0;
                    enc_last_i  = 1'b0;
                end
            end
            enc_hs = enc_valid_i && enc_ready_o;

            if (bp_cnt == 0 && bp_at >= 0 && pix_valid_o && pix_q.size() == bp_at) bp_cnt = 1;
            if (bp_cnt > 0 && bp_cnt <= 10) begin
                pix_ready_i = 1'b0;
                check($sformatf("%s_bp_valid%0d", tag, bp_cnt), pix_valid_o, 1);
                check($sformatf("%s_bp_data%0d", tag, bp_cnt), pix_data_o, in_buf[bp_at]);
                check($sformatf("%s_bp_noread%0d", tag, bp_cnt), cs_b_o && !we_b_o, 0);
                bp_cnt++;
            end else begin
                pix_ready_i = (($urandom % 100) < ready_pct);
            end
            if (pix_valid_o && pix_ready_i) begin
                pix_q.push_back(pix_data_o);
                pixl_q.push_back(pix_last_o);
            end

            if (cs_b_o) begin
                acc_cyc.push_back(cyc); acc_we.push_back(we_b_o); acc_addr.push_back(addr_b_o);
                if (we_b_o) writes++;
            end
        end
        start_i = 1'b0; enc_valid_i = 1'b0; enc_last_i = 1'b0; pix_ready_i = 1'b0;
        @(negedge clk);

        model_len = (n_enc > DEPTH) ? DEPTH : n_enc;
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_pix_count"}, pix_q.size(), DEPTH);
        for (int i = 0; i < pix_q.size() && i < DEPTH; i++) begin
            check($sformatf("%s_pix%0d", tag, i), pix_q[i], in_buf[i]);
            check($sformatf("%s_last%0d", tag, i), pixl_q[i], (i == DEPTH - 1));
        end
        check({tag, "_out_len"}, out_len_o, exp_len);
        check({tag, "_out_len_model"}, out_len_o, model_len);
        check({tag, "_overflow"}, overflow_o, exp_ovf);
        check({tag, "_overflow_model"}, overflow_o, n_enc > DEPTH);
        check({tag, "_writes"}, writes, model_len);
        for (int i = 0; i < model_len; i++)
            check($sformatf("%s_obuf%0d", tag, i), out_buf[i], enc_bytes[i]);
        check({tag, "_sel_after"}, sel_o, 0);
        check({tag, "_busy_after"}, busy_o, 0);
    endtask

    initial begin
        vecs[0] = '{n_enc: 5,  ready_pct: 100, valid_pct: 100, bp_at: -1, start_mid: 0, exp_len: 5,  exp_ovf: 0};
        vecs[1] = '{n_enc: 5,  ready_pct: 100, valid_pct: 50,  bp_at: 7,  start_mid: 0, exp_len: 5,  exp_ovf: 0};
        vecs[2] = '{n_enc: 17, ready_pct: 100, valid_pct: 100, bp_at: -1, start_mid: 0, exp_len: 16, exp_ovf: 1};
        vecs[3] = '{n_enc: 16, ready_pct: 70,  valid_pct: 100, bp_at: -1, start_mid: 0, exp_len: 16, exp_ovf: 0};
        vecs[4] = '{n_enc: 1,  ready_pct: 60,  valid_pct: 100, bp_at: -1, start_mid: 0, exp_len: 1,  exp_ovf: 0};
        vecs[5] = '{n_enc: 8,  ready_pct: 80,  valid_pct: 60,  bp_at: -1, start_mid: 1, exp_len: 8,  exp_ovf: 0};

        // Reset: outputs must be quiet during and right after reset.
        repeat (3) @(negedge clk);
        check("rst_sel", sel_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_enc_ready", enc_ready_o, 0);
        check("rst_cs", cs_b_o, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_sel", sel_o, 0);
        check("rel_busy", busy_o, 0);
        check("rel_done", done_o, 0);
        check("rel_enc_ready", enc_ready_o, 0);
        check("rel_pix", {pix_valid_o, pix_last_o, pix_data_o}, 0);
        check("rel_port", {cs_b_o, we_b_o, addr_b_o, data_b_o}, 0);
        check("rel_len_ovf", {out_len_o, overflow_o}, 0);

        for (int v = 0; v < 6; v++) begin
            run_frame(v, vecs[v].n_enc, vecs[v].ready_pct, vecs[v].valid_pct, vecs[v].bp_at,
                      vecs[v].start_mid, 1'b0, vecs[v].exp_len, vecs[v].exp_ovf);
            if (v == 0) begin
                // A byte accepted in the first RD_ISSUE is written in RD_WAIT; a byte accepted
                // the cycle before the second RD_ISSUE defers that read by one cycle.
                check("col_acc_count", acc_cyc.size() >= 4, 1);
                if (acc_cyc.size() >= 4) begin
                    check("col_a0", {acc_cyc[0][7:0], 7'd0, acc_we[0], 4'd0, acc_addr[0]}, {8'd1, 7'd0, 1'b0, 4'd0, 4'd0});
                    check("col_a1", {acc_cyc[1][7:0], 7'd0, acc_we[1], 4'd0, acc_addr[1]}, {8'd2, 7'd0, 1'b1, 4'd0, 4'd0});
                    check("col_a2", {acc_cyc[2][7:0], 7'd0, acc_we[2], 4'd0, acc_addr[2]}, {8'd4, 7'd0, 1'b1, 4'd0, 4'd1});
                    check("col_a3", {acc_cyc[3][7:0], 7'd0, acc_we[3], 4'd0, acc_addr[3]}, {8'd5, 7'd0, 1'b0, 4'd0, 4'd1});
                end
            end
        end

        // Reset asserted while a pixel is held: outputs drop without waiting for a clock.
        for (int i = 0; i < DEPTH; i++) in_buf[i] = byte_t'(i);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int i = 0; i < 20 && !pix_valid_o; i++) @(negedge clk);
        check("mr_pix_valid_seen", pix_valid_o, 1);
        #2 rst = 1'b0;
        #1;
        check("mr_sel", sel_o, 0);
        check("mr_pix_valid", pix_valid_o, 0);
        check("mr_busy", busy_o, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("mr_idle_after", {sel_o, busy_o, cs_b_o}, 0);

        // Randomized frames against the buffer/stream model.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(20, 1);
            run_frame(10 + r, n, $urandom_range(100, 30), $urandom_range(100, 30),
                      -1, 1'b0, 1'b1, (n > DEPTH) ? DEPTH : n, n > DEPTH);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
